// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings and
// handshake constants carried over from the previous serial divider.
package div_pkg;

  // Handshake values on start_i, matching the existing divider.
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  // Values on ready_o, matching the existing divider.
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Divider states; the first four keep the legacy encodings.
  typedef enum logic [2:0] {
    DIV_FREE    = 3'b000,
    DIV_DIVZERO = 3'b001,
    DIV_ON      = 3'b010,
    DIV_END     = 3'b011,
    DIV_FIX     = 3'b100
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division step on magnitudes: shift {rem,quo} left by one,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Trial subtraction at WIDTH+1 bits; the partial remainder is always below
  // the divisor, so the top bit of the difference is a reliable sign.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (trial[WIDTH] == 1'b0) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter_param.sv
// Parametrised multi-cycle signed/unsigned divider. Operands are captured as
// magnitudes at accept, BITS_PER_CYCLE restoring steps run per clock, and the
// signs are applied in a final fix-up cycle. Result is {remainder, quotient}.
module div_iter_param
  import div_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2,
  parameter int CNT_W          = $clog2(WIDTH / BITS_PER_CYCLE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div_by_zero_o
);

  localparam int               STEPS    = WIDTH / BITS_PER_CYCLE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  // Two's-complement negation when the operand is signed and negative.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                 input logic             is_signed);
    if (is_signed && value[WIDTH-1]) begin
      magnitude = ~value + ONE;
    end else begin
      magnitude = value;
    end
  endfunction

  div_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] rem, rem_next;
  logic [WIDTH-1:0] quo, quo_next;
  logic [WIDTH-1:0] divisor, divisor_next;
  logic             signed_op, signed_op_next;
  logic             sign1, sign1_next;
  logic             sign2, sign2_next;
  logic             dz_flag, dz_flag_next;
  logic [2*WIDTH-1:0] result_next;
  logic             ready_next;
  logic             div_by_zero_next;

  // Chained restoring steps: entry 0 is the registered state, the last entry
  // is the value after this cycle's BITS_PER_CYCLE steps.
  logic [BITS_PER_CYCLE:0][WIDTH-1:0] rem_chain;
  logic [BITS_PER_CYCLE:0][WIDTH-1:0] quo_chain;

  assign rem_chain[0] = rem;
  assign quo_chain[0] = quo;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    div_step #(
      .WIDTH (WIDTH)
    ) u_step (
      .rem      (rem_chain[g]),
      .quo      (quo_chain[g]),
      .divisor  (divisor),
      .rem_next (rem_chain[g+1]),
      .quo_next (quo_chain[g+1])
    );
  end

  // Next-state, datapath and output-register decisions for every state.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    rem_next         = rem;
    quo_next         = quo;
    divisor_next     = divisor;
    signed_op_next   = signed_op;
    sign1_next       = sign1;
    sign2_next       = sign2;
    dz_flag_next     = dz_flag;
    result_next      = result_o;
    ready_next       = ready_o;
    div_by_zero_next = div_by_zero_o;

    case (state)
      DIV_FREE: begin
        if (start_i == DIV_START && annul_i == 1'b0) begin
          signed_op_next = signed_div_i;
          sign1_next     = signed_div_i & opdata1_i[WIDTH-1];
          sign2_next     = signed_div_i & opdata2_i[WIDTH-1];
          quo_next       = magnitude(opdata1_i, signed_div_i);
          divisor_next   = magnitude(opdata2_i, signed_div_i);
          rem_next       = ZERO;
          cnt_next       = {CNT_W{1'b0}};
          if (opdata2_i == ZERO) begin
            dz_flag_next = 1'b1;
            state_next   = DIV_DIVZERO;
          end else begin
            dz_flag_next = 1'b0;
            state_next   = DIV_ON;
          end
        end else begin
          state_next = DIV_FREE;
        end
      end

      DIV_DIVZERO: begin
        if (annul_i) begin
          state_next = DIV_FREE;
        end else begin
          rem_next     = ZERO;
          quo_next     = ZERO;
          dz_flag_next = 1'b1;
          state_next   = DIV_END;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          state_next = DIV_FREE;
        end else begin
          rem_next = rem_chain[BITS_PER_CYCLE];
          quo_next = quo_chain[BITS_PER_CYCLE];
          cnt_next = cnt + CNT_ONE;
          if (cnt == LAST_CNT) begin
            state_next = DIV_FIX;
          end else begin
            state_next = DIV_ON;
          end
        end
      end

      DIV_FIX: begin
        if (annul_i) begin
          state_next = DIV_FREE;
        end else begin
          // Quotient is negative when the signs differ; the remainder
          // follows the dividend. MIN / -1 wraps back to MIN naturally.
          if (signed_op && (sign1 ^ sign2)) begin
            quo_next = ~quo + ONE;
          end else begin
            quo_next = quo;
          end
          if (signed_op && sign1) begin
            rem_next = ~rem + ONE;
          end else begin
            rem_next = rem;
          end
          state_next = DIV_END;
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP) begin
          result_next      = {2*WIDTH{1'b0}};
          ready_next       = DIV_RESULT_NOT_READY;
          div_by_zero_next = 1'b0;
          state_next       = DIV_FREE;
        end else begin
          result_next      = {rem, quo};
          ready_next       = DIV_RESULT_READY;
          div_by_zero_next = dz_flag;
          state_next       = DIV_END;
        end
      end

      default: begin
        result_next      = {2*WIDTH{1'b0}};
        ready_next       = DIV_RESULT_NOT_READY;
        div_by_zero_next = 1'b0;
        state_next       = DIV_FREE;
      end
    endcase
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= DIV_FREE;
      cnt           <= {CNT_W{1'b0}};
      rem           <= ZERO;
      quo           <= ZERO;
      divisor       <= ZERO;
      signed_op     <= 1'b0;
      sign1         <= 1'b0;
      sign2         <= 1'b0;
      dz_flag       <= 1'b0;
      result_o      <= {2*WIDTH{1'b0}};
      ready_o       <= DIV_RESULT_NOT_READY;
      div_by_zero_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      rem           <= rem_next;
      quo           <= quo_next;
      divisor       <= divisor_next;
      signed_op     <= signed_op_next;
      sign1         <= sign1_next;
      sign2         <= sign2_next;
      dz_flag       <= dz_flag_next;
      result_o      <= result_next;
      ready_o       <= ready_next;
      div_by_zero_o <= div_by_zero_next;
      busy_o        <= (state_next != DIV_FREE);
    end
  end

endmodule

// File: tb/tb_div_iter_param.sv
// Scoreboard bench for div_iter_param at default parameters: the driver pushes
// hand-computed expectations, an independent monitor checks each ready_o.
module tb_div_iter_param;

  localparam int WIDTH  = 32;
  localparam int BPC    = 2;
  // Edges counted with the accept edge as edge 1.
  localparam int LAT_DIV = WIDTH / BPC + 3;
  localparam int LAT_DZ  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              annul_i;
  logic              signed_div_i;
  logic [WIDTH-1:0]  opdata1_i;
  logic [WIDTH-1:0]  opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic              ready_o;
  logic              busy_o;
  logic              div_by_zero_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [2*WIDTH-1:0] res;
    logic               dz;
    int                 cyc;
  } exp_t;

  exp_t q[$];

  div_iter_param #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BPC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .annul_i       (annul_i),
    .signed_div_i  (signed_div_i),
    .opdata1_i     (opdata1_i),
    .opdata2_i     (opdata2_i),
    .result_o      (result_o),
    .ready_o       (ready_o),
    .busy_o        (busy_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest expectation.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_o === 1'b1 && !prev) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got result %h with nothing pending", result_o);
        end else begin
          e = q.pop_front();
          chk("result", result_o, e.res);
          chk("div_by_zero", {63'd0, div_by_zero_o}, {63'd0, e.dz});
          chk("latency_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      prev = (ready_o === 1'b1);
    end
  end

  // Issue one divide, hold start through ready, then release and check clear.
  task automatic run_div(input logic sg, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic edz, input int lat);
    exp_t e;
    int   got;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      if (!busy_o && !ready_o) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("idle_before_issue", 64'(got), 64'd1);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    e.res = {er, eq};
    e.dz  = edz;
    e.cyc = cyc + lat;
    q.push_back(e);
    @(negedge clk);
    // Inputs after the accept edge must not influence the result.
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sg;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      if (ready_o) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (got == 0) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no ready_o, required one within 60 cycles");
      if (q.size() > 0) e = q.pop_front();
    end else begin
      repeat (2) @(negedge clk);
      chk("hold_ready", {63'd0, ready_o}, 64'd1);
      chk("hold_result", result_o, {er, eq});
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("clear_ready", {63'd0, ready_o}, 64'd0);
    chk("clear_result", result_o, 64'd0);
    chk("clear_dz", {63'd0, div_by_zero_o}, 64'd0);
    chk("clear_busy", {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_dz", {63'd0, div_by_zero_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // signed, dividend, divisor, quotient, remainder, div-by-zero, latency
    run_div(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, LAT_DIV);
    run_div(1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, LAT_DIV);
    run_div(1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, LAT_DIV);
    run_div(1'b0, 32'h00001234,   32'd0,          32'd0,          32'd0,          1'b1, LAT_DZ);
    run_div(1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, LAT_DIV);
    run_div(1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, LAT_DIV);
    run_div(1'b0, 32'hFFFFFFFF,   32'h00010000,   32'h0000FFFF,   32'h0000FFFF,   1'b0, LAT_DIV);
    run_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, LAT_DIV);
    run_div(1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, LAT_DIV);
    run_div(1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          1'b1, LAT_DZ);
    run_div(1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, LAT_DIV);

    // Annul during ON: no result may appear, the unit returns to idle.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (5) @(negedge clk);
    chk("busy_in_on", {63'd0, busy_o}, 64'd1);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_busy", {63'd0, busy_o}, 64'd0);
    chk("annul_ready", {63'd0, ready_o}, 64'd0);
    repeat (25) @(negedge clk);
    run_div(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, LAT_DIV);

    // Synchronous reset in the middle of ON.
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    repeat (6) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy_o}, 64'd0);
    chk("midrst_ready", {63'd0, ready_o}, 64'd0);
    chk("midrst_result", result_o, 64'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, LAT_DIV);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
